// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state encoding, opcode map and defaults for mc_control_unit
package mc_ctrl_pkg;
  localparam int OP_W_DEF = 4;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;
  localparam logic [7:0] OP_ALU_R  = 8'd0;
  localparam logic [7:0] OP_ALU_I  = 8'd1;
  localparam logic [7:0] OP_LOAD   = 8'd2;
  localparam logic [7:0] OP_STORE  = 8'd3;
  localparam logic [7:0] OP_BRANCH = 8'd4;
  localparam logic [7:0] OP_JUMP   = 8'd5;
  function automatic logic op_legal(input logic [7:0] op);
    return op <= OP_JUMP;
  endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: 8-bit wait counter flagging when the count reaches limit
module mc_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= 8'd0;
    else if (en) cnt <= cnt + 8'd1;
  assign expired = cnt == limit;
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: Moore control FSM sequencing decode, execute, memory and writeback
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = OP_W_DEF,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [OP_W-1:0] opcode,
  output logic            instr_ready,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            branch_en,
  output logic            jump_en,
  output logic            immediate_en,
  output logic            reg_write,
  output logic            fault,
  input  logic            fault_clr,
  output logic [2:0]      state_o
);
  state_t state, state_nx;
  logic [OP_W-1:0] op_q;
  logic [7:0] op;
  logic expired, alu_r, alu_i, ld, st, br, jp;
  assign op    = 8'(op_q);
  assign alu_r = op == OP_ALU_R;
  assign alu_i = op == OP_ALU_I;
  assign ld    = op == OP_LOAD;
  assign st    = op == OP_STORE;
  assign br    = op == OP_BRANCH;
  assign jp    = op == OP_JUMP;
  assign state_o = state;
  mc_wait_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != S_MEM),
    .en      (state == S_MEM && !mem_ack),
    .limit   (8'(MEM_TIMEOUT - 1)),
    .expired (expired)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && instr_valid) op_q <= opcode;
    end
  always_comb begin
    state_nx     = state;
    instr_ready  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    branch_en    = 1'b0;
    jump_en      = 1'b0;
    immediate_en = 1'b0;
    reg_write    = 1'b0;
    fault        = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        state_nx    = instr_valid ? S_DECODE : S_IDLE;
      end
      S_DECODE: state_nx = op_legal(op) ? S_EXEC : S_FAULT;
      S_EXEC: begin
        immediate_en = alu_i || ld || st;
        branch_en    = br;
        jump_en      = jp;
        state_nx     = (alu_r || alu_i) ? S_WB : (ld || st) ? S_MEM : S_IDLE;
      end
      // an ack in the expiry cycle still completes the access
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = st;
        state_nx = mem_ack ? (ld ? S_WB : S_IDLE) : expired ? S_FAULT : S_MEM;
      end
      S_WB: begin
        reg_write = 1'b1;
        state_nx  = S_IDLE;
      end
      S_FAULT: begin
        fault    = 1'b1;
        state_nx = fault_clr ? S_IDLE : S_FAULT;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 The block SHALL have parameter OP_W, default 4, meaning opcode width; legal range 3..8.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of MEM-state cycles allowed without mem_ack; legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port instr_valid, input, 1 bit: an opcode is offered.
REQ-006 The block SHALL have port opcode, input, OP_W bits: the offered opcode.
REQ-007 The block SHALL have port instr_ready, output, 1 bit: the block accepts an opcode this cycle.
REQ-008 The block SHALL have port mem_ack, input, 1 bit: the memory access is complete.
REQ-009 The block SHALL have port mem_req, output, 1 bit: a memory access is requested.
REQ-010 The block SHALL have port mem_we, output, 1 bit: the memory access is a write.
REQ-011 The block SHALL have port branch_en, output, 1 bit: branch strobe.
REQ-012 The block SHALL have port jump_en, output, 1 bit: jump strobe.
REQ-013 The block SHALL have port immediate_en, output, 1 bit: the ALU source is the immediate.
REQ-014 The block SHALL have port reg_write, output, 1 bit: register-file write strobe.
REQ-015 The block SHALL have port fault, output, 1 bit: illegal opcode or memory timeout.
REQ-016 The block SHALL have port fault_clr, input, 1 bit: leave the FAULT state.
REQ-017 The block SHALL have port state_o, output, 3 bits: current state encoding, for debug.

Function
REQ-018 The block SHALL implement states IDLE, DECODE, EXEC, MEM, WB and FAULT; all outputs SHALL be decoded from registered state and the latched opcode only (Moore outputs).
REQ-019 The opcode map SHALL be: 0 ALU_R; 1 ALU_I; 2 LOAD; 3 STORE; 4 BRANCH; 5 JUMP; every other value is illegal. Values are zero-extended to OP_W.
REQ-020 IDLE: instr_ready = 1; when instr_valid = 1, latch opcode and go to DECODE. instr_ready SHALL be 0 in every other state.
REQ-021 DECODE: lasts one cycle; an illegal opcode goes to FAULT, otherwise go to EXEC.
REQ-022 EXEC: lasts one cycle.
- immediate_en = 1 for ALU_I, LOAD and STORE.
- branch_en = 1 for BRANCH.
- jump_en = 1 for JUMP.
- Next state: ALU_R or ALU_I go to WB; LOAD or STORE go to MEM; BRANCH or JUMP go to IDLE.
REQ-023 MEM:
- mem_req = 1 throughout the state.
- mem_we = 1 only for STORE.
- An 8-bit wait counter, cleared on entry, increments each cycle without mem_ack.
REQ-024 MEM exit on mem_ack: LOAD goes to WB; STORE goes to IDLE.
REQ-025 MEM timeout: when the counter reaches MEM_TIMEOUT-1 with no mem_ack, go to FAULT. If mem_ack arrives in that same cycle, the ack SHALL win.
REQ-026 WB: reg_write = 1 for exactly one cycle, then go to IDLE.
REQ-027 FAULT: fault = 1 and all strobes are 0. Go to IDLE on fault_clr = 1; otherwise stay in FAULT.
REQ-028 Latency from the accept edge:
- ALU_R and ALU_I: 4 cycles.
- BRANCH and JUMP: 3 cycles.
- LOAD: 4 cycles plus the MEM cycles.
- STORE: 3 cycles plus the MEM cycles.
- Back-to-back acceptance SHALL be possible on the first IDLE cycle after completion.
REQ-029 instr_valid and opcode SHALL be ignored outside IDLE; mem_ack SHALL be ignored outside MEM; fault_clr SHALL be ignored outside FAULT.
REQ-030 At most one of branch_en, jump_en, reg_write and mem_req SHALL be 1 in any cycle.

Reset
REQ-031 When rst_n = 0 at a clock edge, the block SHALL enter IDLE, clear the latched opcode and the wait counter, and drive fault, mem_req, mem_we, branch_en, jump_en, immediate_en and reg_write to 0.
REQ-032 Reset SHALL take priority in any state, including mid-MEM; mem_req SHALL drop on the first edge with rst_n = 0. instr_ready SHALL be 1 from the first cycle after reset.

Structure
REQ-033 The state enumeration, the opcode constants and the OP_W default SHALL live in the shared package mc_ctrl_pkg.
REQ-034 The MEM wait counter SHALL be a sub-module named mc_wait_timer, with ports clear, en, limit and expired.

Verification
REQ-035 ALU_I: opcode = 1 accepted at edge 0 -> immediate_en = 1 in cycle 2, reg_write = 1 in cycle 3, instr_ready = 1 in cycle 4.
REQ-036 LOAD with mem_ack at the 3rd MEM cycle -> mem_req = 1 for 3 cycles with mem_we = 0, then reg_write pulses for 1 cycle, then the block returns to IDLE.
REQ-037 STORE with no mem_ack, MEM_TIMEOUT = 4 -> mem_req and mem_we = 1 for 4 cycles, then fault = 1 and fault holds until fault_clr = 1, then IDLE; a second run with ack in the 4th cycle -> no fault.
REQ-038 Opcode = 9 -> fault = 1 two cycles after accept with no strobes pulsed; instr_valid = 1 during FAULT -> ignored.
REQ-039 rst_n = 0 during the 2nd MEM cycle of a LOAD -> mem_req = 0 after that edge, then IDLE with no reg_write pulse.
REQ-040 BRANCH, then JUMP offered back-to-back -> branch_en in cycle 2, jump_en in cycle 5, never both 1 in the same cycle.
